// File: rtl/mem_pkg.sv
// Shared constants, request-decode type and helper for the memory client block.
package mem_pkg;

    localparam int BITS_ADDR   = 14;
    localparam int BITS_DATA   = 8;
    localparam int RD_LATENCY  = 3;
    localparam int RSP_DEPTH   = 4;
    localparam int PIPE_STAGES = RD_LATENCY + 1;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

    // A request only becomes an operation on a valid&ready handshake.
    function automatic op_e decode_op(input logic valid, input logic ready, input logic we);
        if (!(valid && ready))
            return OP_IDLE;
        return we ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Shift-register response FIFO: the head entry is itself the output register,
// so data is stable while stalled and visible the cycle after a push.
module mem_rsp_fifo
#(
    parameter int WIDTH = mem_pkg::BITS_DATA,
    parameter int DEPTH = mem_pkg::RSP_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] entries [DEPTH];
    logic             pop;
    logic [CW-1:0]    wr_idx;
    logic [CW-1:0]    count_nxt;

    always_comb begin
        pop       = rsp_valid & pop_ready;
        wr_idx    = pop ? count - CW'(1) : count;
        count_nxt = count + CW'(push) - CW'(pop);
    end

    // The push write comes after the shift so a simultaneous push/pop lands correctly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++)
                    entries[i] <= entries[i + 1];
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_idx == CW'(i)))
                    entries[i] <= push_data;
            end
            count     <= count_nxt;
            rsp_valid <= (count_nxt != '0);
        end
    end

    assign rsp_data = entries[0];

endmodule

// File: rtl/mem_client.sv
// Initiator-side controller for the 3-cycle-latency dual-port memory: registered
// memory ports, in-flight read tracking and credit-limited in-order responses.
module mem_client
#(
    parameter int BITS_ADDR  = mem_pkg::BITS_ADDR,
    parameter int BITS_DATA  = mem_pkg::BITS_DATA,
    parameter int RD_LATENCY = mem_pkg::RD_LATENCY,
    parameter int RSP_DEPTH  = mem_pkg::RSP_DEPTH
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BITS_ADDR-1:0] req_addr,
    input  logic [BITS_DATA-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BITS_DATA-1:0] rsp_data,
    output logic [BITS_ADDR-1:0] addr_rd,
    input  logic [BITS_DATA-1:0] q,
    output logic [BITS_ADDR-1:0] addr_wr,
    output logic [BITS_DATA-1:0] data_wr,
    output logic                 wren
);

    import mem_pkg::*;

    localparam int STAGES = RD_LATENCY + 1;
    localparam int CW     = $clog2(RSP_DEPTH + 1);

    op_e               op;
    logic [STAGES-1:0] pend;
    logic [CW-1:0]     used;
    logic [CW-1:0]     fifo_count;
    logic              fifo_push;
    logic              fifo_pop;
    logic              rd_accept;

    // Ready depends only on the credit register, so writes are throttled too.
    assign req_ready = (used < CW'(RSP_DEPTH));
    assign op        = decode_op(req_valid, req_ready, req_we);
    assign rd_accept = (op == OP_READ);
    assign fifo_push = pend[STAGES-1];
    assign fifo_pop  = (fifo_count != '0) & rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_rd <= '0;
            addr_wr <= '0;
            data_wr <= '0;
            wren    <= 1'b0;
        end else begin
            wren <= (op == OP_WRITE);
            if (op == OP_WRITE) begin
                addr_wr <= req_addr;
                data_wr <= req_wdata;
            end
            if (rd_accept)
                addr_rd <= req_addr;
        end
    end

    // One stage per clock of memory latency plus the addr_rd register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pend <= '0;
        else
            pend <= {pend[STAGES-2:0], rd_accept};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            used <= '0;
        else if (rd_accept && !fifo_pop)
            used <= used + CW'(1);
        else if (!rd_accept && fifo_pop)
            used <= used - CW'(1);
    end

    mem_rsp_fifo #(
        .WIDTH (BITS_DATA),
        .DEPTH (RSP_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (q),
        .pop_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .count     (fifo_count)
    );

endmodule
